// File: rtl/brpred_pkg.sv
// Shared types, funct3 encodings and the saturating-counter step function
// used by the branch predictor.
package brpred_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Two-bit saturating counter: count up on taken, down on not-taken,
  // clamping at ST and SNT.
  function automatic cnt_e sat_next(input cnt_e cnt, input logic taken);
    cnt_e nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != ST) nxt = cnt_e'(cnt + 2'd1);
    end else begin
      if (cnt != SNT) nxt = cnt_e'(cnt - 2'd1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bht_table.sv
// Direct-mapped branch history table: 2**IDX_W two-bit counters held in
// flops, one combinational read port and one synchronous write port.
module bht_table
  import brpred_pkg::*;
#(
  parameter int         IDX_W    = 6,
  parameter logic [1:0] INIT_CNT = 2'b01
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [IDX_W-1:0] i_rd_idx,
  output cnt_e             o_rd_cnt,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  cnt_e             i_wr_cnt
);

  localparam int ENTRIES = 2 ** IDX_W;

  cnt_e cnt_q [ENTRIES];
  cnt_e cnt_d [ENTRIES];

  // Read straight from the registered array, so a same-cycle write is not
  // visible until the next cycle.
  assign o_rd_cnt = cnt_q[i_rd_idx];

  // Next-state of the array: hold everything, overwrite the written entry.
  always_comb begin
    // NOTE: start from the held value so every path assigns cnt_d; a
    // missing default here would infer latches.
    cnt_d = cnt_q;
    if (i_wr_en) cnt_d[i_wr_idx] = i_wr_cnt;
  end

  // Table state register with synchronous initialisation of every entry.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      // NOTE: this table is a flop array, not a RAM macro, so each entry
      // can and must be initialised; a real SRAM would need an init sweep.
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= cnt_e'(INIT_CNT);
    end else begin
      // NOTE: non-blocking assignment for all sequential state so every
      // flop samples pre-edge values.
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Branch resolution and 2-bit bimodal prediction: decodes funct3 against
// the comparator flags, trains a PC-indexed counter table and keeps
// saturating statistics of resolved branches and mispredictions.
module branch_predictor
  import brpred_pkg::*;
#(
  parameter int         IDX_W    = 6,
  parameter int         PC_W     = 32,
  parameter logic [1:0] INIT_CNT = 2'b01,
  parameter int         STAT_W   = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [PC_W-1:0]   i_fetch_pc,
  output logic              o_pred_taken,
  input  logic              i_br_valid,
  input  logic [PC_W-1:0]   i_br_pc,
  input  logic [2:0]        i_funct3,
  input  logic              i_pred_taken_ex,
  output logic              o_br_un,
  input  logic              i_br_equal,
  input  logic              i_br_less,
  output logic              o_br_taken,
  output logic              o_mispredict,
  output logic              o_br_illegal,
  output logic [STAT_W-1:0] o_br_count,
  output logic [STAT_W-1:0] o_miss_count
);

  logic [IDX_W-1:0]  fetch_idx;
  logic [IDX_W-1:0]  br_idx;
  cnt_e              fetch_cnt;
  cnt_e              br_cnt;
  cnt_e              br_cnt_next;
  logic              legal;
  logic              outcome;
  logic              miss;
  logic [STAT_W-1:0] br_count_q,   br_count_d;
  logic [STAT_W-1:0] miss_count_q, miss_count_d;

  // Word-aligned PCs: drop the byte-offset bits, aliasing is accepted.
  assign fetch_idx = i_fetch_pc[IDX_W+1:2];
  assign br_idx    = i_br_pc[IDX_W+1:2];

  // Fetch-side read; the resolve side has its own read of the same array
  // through the training path below.
  bht_table #(
    .IDX_W    (IDX_W),
    .INIT_CNT (INIT_CNT)
  ) u_bht (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_rd_idx (fetch_idx),
    .o_rd_cnt (fetch_cnt),
    .i_wr_en  (legal),
    .i_wr_idx (br_idx),
    .i_wr_cnt (br_cnt_next)
  );

  // Second read of the resolving entry to compute its trained value.
  bht_table #(
    .IDX_W    (IDX_W),
    .INIT_CNT (INIT_CNT)
  ) u_bht_shadow (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_rd_idx (br_idx),
    .o_rd_cnt (br_cnt),
    .i_wr_en  (legal),
    .i_wr_idx (br_idx),
    .i_wr_cnt (br_cnt_next)
  );

  assign br_cnt_next  = sat_next(br_cnt, outcome);
  assign o_pred_taken = fetch_cnt[1];
  assign o_br_un      = i_funct3[1];

  // funct3 decode and outcome resolution against the comparator flags.
  always_comb begin
    outcome = 1'b0;
    legal   = i_br_valid;
    unique case (i_funct3)
      F3_BEQ:  outcome = i_br_equal;
      F3_BNE:  outcome = ~i_br_equal;
      F3_BLT,
      F3_BLTU: outcome = i_br_less;
      F3_BGE,
      F3_BGEU: outcome = ~i_br_less;
      default: legal   = 1'b0;
    endcase
  end

  assign miss         = legal & (outcome != i_pred_taken_ex);
  assign o_br_taken   = legal & outcome;
  assign o_mispredict = miss;
  assign o_br_illegal = i_br_valid & ~legal;

  // Statistics next-state: increment on event, hold at all-ones.
  always_comb begin
    br_count_d   = br_count_q;
    miss_count_d = miss_count_q;
    if (legal && (br_count_q != '1))  br_count_d   = br_count_q + 1'b1;
    if (miss  && (miss_count_q != '1)) miss_count_d = miss_count_q + 1'b1;
  end

  // Statistics registers, cleared by reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      br_count_q   <= '0;
      miss_count_q <= '0;
    end else begin
      br_count_q   <= br_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign o_br_count   = br_count_q;
  assign o_miss_count = miss_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor. A second instance with narrow
// statistics counters shares all stimulus to exercise counter saturation.
module tb_branch_predictor;
  import brpred_pkg::*;

  localparam int PC_W = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [PC_W-1:0] fetch_pc;
  logic            br_valid;
  logic [PC_W-1:0] br_pc;
  logic [2:0]      funct3;
  logic            pred_ex;
  logic            br_equal;
  logic            br_less;

  logic            pred_taken, br_un, br_taken, mispredict, br_illegal;
  logic [31:0]     br_count, miss_count;

  logic            s_pred_taken, s_br_un, s_br_taken, s_mispredict, s_br_illegal;
  logic [1:0]      s_br_count, s_miss_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_fetch_pc      (fetch_pc),
    .o_pred_taken    (pred_taken),
    .i_br_valid      (br_valid),
    .i_br_pc         (br_pc),
    .i_funct3        (funct3),
    .i_pred_taken_ex (pred_ex),
    .o_br_un         (br_un),
    .i_br_equal      (br_equal),
    .i_br_less       (br_less),
    .o_br_taken      (br_taken),
    .o_mispredict    (mispredict),
    .o_br_illegal    (br_illegal),
    .o_br_count      (br_count),
    .o_miss_count    (miss_count)
  );

  branch_predictor #(.STAT_W(2)) dut_sat (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_fetch_pc      (fetch_pc),
    .o_pred_taken    (s_pred_taken),
    .i_br_valid      (br_valid),
    .i_br_pc         (br_pc),
    .i_funct3        (funct3),
    .i_pred_taken_ex (pred_ex),
    .o_br_un         (s_br_un),
    .i_br_equal      (br_equal),
    .i_br_less       (br_less),
    .o_br_taken      (s_br_taken),
    .o_mispredict    (s_mispredict),
    .o_br_illegal    (s_br_illegal),
    .o_br_count      (s_br_count),
    .o_miss_count    (s_miss_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [PC_W-1:0] pc, input logic [2:0] f3,
                       input logic pe, input logic eq, input logic lt);
    br_valid = v;
    br_pc    = pc;
    funct3   = f3;
    pred_ex  = pe;
    br_equal = eq;
    br_less  = lt;
  endtask

  task automatic idle();
    drive(1'b0, '0, F3_BEQ, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n    = 1'b0;
    fetch_pc = 32'h100;
    idle();
    tick();
    tick();
    rst_n = 1'b1;
    #1;

    // Reset state.
    check("rst_pred",  pred_taken, 0);
    check("rst_br",    br_count,   0);
    check("rst_miss",  miss_count, 0);

    // BEQ taken three times at 0x100, predicted not-taken each time.
    drive(1'b1, 32'h100, F3_BEQ, 1'b0, 1'b1, 1'b0);
    #1;
    check("beq_taken",     br_taken,   1);
    check("beq_misp",      mispredict, 1);
    check("beq_un",        br_un,      0);
    check("beq_pred_old",  pred_taken, 0);
    tick();
    check("beq1_pred",     pred_taken, 1);
    check("beq1_miss",     miss_count, 1);
    check("beq1_br",       br_count,   1);
    tick();
    check("beq2_miss",     miss_count, 2);
    tick();
    check("beq3_miss",     miss_count, 3);
    check("beq3_br",       br_count,   3);
    check("beq3_pred",     pred_taken, 1);

    // Aliasing: 0x200 shares index 0 with 0x100 (now strongly taken).
    fetch_pc = 32'h200;
    drive(1'b1, 32'h200, F3_BNE, 1'b1, 1'b1, 1'b0);
    #1;
    check("alias_pred",    pred_taken, 1);
    check("bne_taken",     br_taken,   0);
    check("bne_misp",      mispredict, 1);
    tick();
    check("alias_11to10",  pred_taken, 1);
    tick();
    idle();
    fetch_pc = 32'h100;
    #1;
    check("alias_back",    pred_taken, 0);
    check("alias_miss",    miss_count, 5);
    check("alias_br",      br_count,   5);
    check("sat_miss",      s_miss_count, 3);
    check("sat_br",        s_br_count,   3);

    // Unsigned and signed compares at 0x104 (index 1).
    fetch_pc = 32'h104;
    drive(1'b1, 32'h104, F3_BLTU, 1'b1, 1'b0, 1'b1);
    #1;
    check("bltu_un",       br_un,      1);
    check("bltu_taken",    br_taken,   1);
    check("bltu_misp",     mispredict, 0);
    tick();
    check("bltu_pred",     pred_taken, 1);
    drive(1'b1, 32'h104, F3_BGE, 1'b0, 1'b0, 1'b1);
    #1;
    check("bge_un",        br_un,      0);
    check("bge_taken",     br_taken,   0);
    check("bge_misp",      mispredict, 0);
    tick();
    check("bge_pred",      pred_taken, 0);
    check("bge_br",        br_count,   7);

    // Illegal funct3 values: no outcome, no training, no statistics.
    drive(1'b1, 32'h104, 3'b010, 1'b0, 1'b1, 1'b1);
    #1;
    check("ill010_flag",   br_illegal, 1);
    check("ill010_taken",  br_taken,   0);
    check("ill010_misp",   mispredict, 0);
    tick();
    drive(1'b1, 32'h104, 3'b011, 1'b0, 1'b1, 1'b1);
    #1;
    check("ill011_flag",   br_illegal, 1);
    tick();
    idle();
    #1;
    check("ill_pred",      pred_taken, 0);
    check("ill_br",        br_count,   7);
    check("ill_miss",      miss_count, 5);
    check("idle_illegal",  br_illegal, 0);

    // Reset during a taken update at 0x100: reset wins.
    fetch_pc = 32'h100;
    drive(1'b1, 32'h100, F3_BEQ, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle();
    #1;
    check("rstupd_pred",   pred_taken, 0);
    check("rstupd_br",     br_count,   0);
    check("rstupd_miss",   miss_count, 0);
    check("rstupd_smiss",  s_miss_count, 0);

    // Same-cycle fetch and update of 0x200: old value this cycle.
    fetch_pc = 32'h200;
    drive(1'b1, 32'h200, F3_BEQ, 1'b0, 1'b1, 1'b0);
    #1;
    check("same_old",      pred_taken, 0);
    tick();
    idle();
    #1;
    check("same_new",      pred_taken, 1);

    // Lower saturation at 0x108: 01 -> 00 -> 00, then taken -> 01.
    fetch_pc = 32'h108;
    drive(1'b1, 32'h108, F3_BNE, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    drive(1'b1, 32'h108, F3_BEQ, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    #1;
    check("low_sat_pred",  pred_taken, 0);
    drive(1'b1, 32'h108, F3_BEQ, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    #1;
    check("low_sat_up",    pred_taken, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
